// File: rtl/uart_pkg.sv
// Shared UART constants and receiver FSM encoding.
// Holds the default line settings and the derived clocks-per-oversample-tick count.
// Both the receiver and the future transmitter import these settings.
package uart_pkg;

  localparam int CLK_FREQ   = 50_000_000;
  localparam int BAUDRATE   = 115200;
  localparam int OVERSAMPLE = 16;

  // Integer division: 50e6 / (115200*16) = 27 clk per oversample tick.
  localparam int BAUD_TICKS = CLK_FREQ / (BAUDRATE * OVERSAMPLE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Free-running oversample tick generator: one-clk tick every BAUD_TICKS clocks.
// Ports: clk (rising edge), reset (async, active-low), tick (registered one-clk strobe).
// No backpressure; the counter runs whenever reset is released.
module uart_baud_tick_gen #(
  parameter int BAUD_TICKS = 27
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(BAUD_TICKS - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, mid-bit sampling, LSB first.
// Ports: clk, reset (async active-low), rx (async serial in, idle high),
//        rx_data (last good byte, held), rx_valid (one-clk strobe, ~9.5 bit times after start edge).
// No backpressure: the downstream decoder must accept every rx_valid strobe.
module uart_rx #(
  parameter int CLK_FREQ   = uart_pkg::CLK_FREQ,
  parameter int BAUDRATE   = uart_pkg::BAUDRATE,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  import uart_pkg::*;

  localparam int         RX_BAUD_TICKS = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
  localparam logic [3:0] S_HALF        = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] S_LAST        = 4'(OVERSAMPLE - 1);

  logic       tick;
  logic       sync1, sync2;
  logic       rx_s;
  rx_state_t  state;
  logic [3:0] s_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  // Cleared by a framing error so a held-low line (break) cannot look like a new start bit.
  logic       armed;

  uart_baud_tick_gen #(
    .BAUD_TICKS(RX_BAUD_TICKS)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Two-flop synchroniser, reset to the idle (high) line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  assign rx_s = sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      s_cnt    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      armed    <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!armed) begin
            if (rx_s) armed <= 1'b1;
          end else if (!rx_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            // Half a bit after the falling edge: still low means a real start bit.
            if (s_cnt == S_HALF) begin
              s_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt == S_LAST) begin
              shreg   <= {rx_s, shreg[7:1]};
              s_cnt   <= '0;
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_cnt == S_LAST) begin
              if (rx_s) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                armed <= 1'b0;
              end
              // Leaving at mid-stop lets a back-to-back start bit be caught.
              state <= IDLE;
              s_cnt <= '0;
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus hand-written corner sequences.
// Clock 20 time units, bit period 8640 units (432 clk).
// A negedge monitor counts rx_valid pulses and records received bytes.
module tb_uart_rx;

  localparam int BIT_NS = 8640;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;

  uart_rx dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );

  always #10 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int         pulses  = 0;
  int         consec  = 0;
  int         stray   = 0;
  logic       prev_v  = 1'b0;
  logic [7:0] prev_d  = 8'h00;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid) begin
        pulses++;
        got_q.push_back(rx_data);
      end
      if (rx_valid && prev_v) consec++;
      if (!rx_valid && rx_data !== prev_d) stray++;
    end
    prev_v = rx_valid;
    prev_d = rx_data;
  end

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    int         bit_ns;
    int         exp_pulses;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_ns);
    logic [7:0] b;
    b  = d;
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop;
    #(bit_ns);
    rx = 1'b1;
  endtask

  initial begin
    int         base;
    int         qbase;
    logic [7:0] d0;
    logic [7:0] b55;

    //            data   stop  bit_ns  pulses  rx_data
    vecs[0] = '{8'h23, 1'b1, BIT_NS, 1, 8'h23};
    vecs[1] = '{8'hA5, 1'b0, BIT_NS, 0, 8'h23};  // framing error keeps old byte
    vecs[2] = '{8'h3C, 1'b1, BIT_NS, 1, 8'h3C};
    vecs[3] = '{8'h81, 1'b1, 8813,   1, 8'h81};  // +2% slow sender
    vecs[4] = '{8'h18, 1'b1, BIT_NS, 1, 8'h18};
    vecs[5] = '{8'h81, 1'b1, 8467,   1, 8'h81};  // -2% fast sender

    // Reset state.
    #1000;
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_rx_data", int'(rx_data), 8'h00);
    reset = 1'b1;
    #200;
    settle();
    check("pre_frame_rx_data", int'(rx_data), 8'h00);

    for (int v = 0; v < 6; v++) begin
      base = pulses;
      send_frame(vecs[v].dat, vecs[v].stop, vecs[v].bit_ns);
      #(BIT_NS / 2);
      settle();
      check($sformatf("vec%0d_pulses", v), pulses - base, vecs[v].exp_pulses);
      check($sformatf("vec%0d_rx_data", v), int'(rx_data), int'(vecs[v].exp_data));
    end

    // Back-to-back frames with no idle gap.
    base  = pulses;
    qbase = got_q.size();
    send_frame(8'h00, 1'b1, BIT_NS);
    send_frame(8'hFF, 1'b1, BIT_NS);
    #(BIT_NS / 2);
    settle();
    check("b2b_pulses", pulses - base, 2);
    check("b2b_first", (got_q.size() > qbase) ? int'(got_q[qbase]) : -1, 8'h00);
    check("b2b_second", (got_q.size() > qbase + 1) ? int'(got_q[qbase + 1]) : -1, 8'hFF);

    // Short low glitch must be rejected at the mid-start re-check.
    d0   = rx_data;
    base = pulses;
    rx   = 1'b0;
    #100;
    rx   = 1'b1;
    #(BIT_NS);
    settle();
    check("glitch_pulses", pulses - base, 0);
    check("glitch_rx_data", int'(rx_data), int'(d0));

    // Reset in the middle of the data bits of 0x55.
    b55  = 8'h55;
    base = pulses;
    rx   = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 3; i++) begin
      rx = b55[i];
      #(BIT_NS);
    end
    rx = b55[3];
    #(BIT_NS / 2);
    reset = 1'b0;
    rx    = 1'b1;
    #1000;
    settle();
    check("midreset_rx_valid", int'(rx_valid), 0);
    check("midreset_rx_data", int'(rx_data), 8'h00);
    reset = 1'b1;
    #(BIT_NS);
    settle();
    check("midreset_no_pulse", pulses - base, 0);
    send_frame(8'h5A, 1'b1, BIT_NS);
    #(BIT_NS / 2);
    settle();
    check("after_reset_pulses", pulses - base, 1);
    check("after_reset_rx_data", int'(rx_data), 8'h5A);

    // Whole-run properties.
    check("consecutive_valid", consec, 0);
    check("rx_data_change_without_valid", stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
